dlx_instr_loader: RTL

- Field-level encoder and instruction-memory writer for the DLX processor. It is the producing end of the instruction word that the IR stage decodes.
- Accepts decoded instruction fields through a valid/ready handshake and packs them into the 32-bit DLX R-type or I-type word.
- Writes each word into instruction memory at consecutive addresses, using a request/acknowledge handshake.
- Used by the program-loading path before the core leaves reset.

---
 rtl/dlx_instr_loader_if.sv | 34 +++
 rtl/dlx_instr_loader.sv | 89 ++++++++
 2 files changed

// File: rtl/dlx_instr_loader_if.sv
// Field-input and instruction-memory write bus of the DLX instruction loader.
// The slave side is the loader; the master side is the field producer and the memory.
interface dlx_instr_loader_if #(
  parameter int AW = 10
);
  logic          LOAD_START;
  logic [AW-1:0] START_ADDR;
  logic          IN_VALID;
  logic          IN_READY;
  logic [5:0]    OPCODE;
  logic [4:0]    RS1;
  logic [4:0]    RS2;
  logic [4:0]    RD;
  logic [31:0]   IMM;
  logic [2:0]    FUNC;
  logic          MEM_REQ;
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [31:0]   MEM_DOUT;
  logic          MEM_ACK;
  logic [AW:0]   COUNT;
  logic          FULL;
  logic          ERR;

  modport slave (
    input  LOAD_START, START_ADDR, IN_VALID, OPCODE, RS1, RS2, RD, IMM, FUNC, MEM_ACK,
    output IN_READY, MEM_REQ, MEM_WE, MEM_ADDR, MEM_DOUT, COUNT, FULL, ERR
  );

  modport master (
    output LOAD_START, START_ADDR, IN_VALID, OPCODE, RS1, RS2, RD, IMM, FUNC, MEM_ACK,
    input  IN_READY, MEM_REQ, MEM_WE, MEM_ADDR, MEM_DOUT, COUNT, FULL, ERR
  );
endinterface

// File: rtl/dlx_instr_loader.sv
// Packs DLX R/I-type fields into 32-bit words and writes them to consecutive memory addresses.
// MEM_REQ rises one cycle after accept; IN_READY is low while a write is pending, on FULL or LOAD_START.
module dlx_instr_loader #(
  parameter int            AW        = 10,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int            MAX_WORDS = 1024
) (
  input logic              CLK,
  input logic              RESET_N,
  dlx_instr_loader_if.slave bus
);
  typedef enum logic {IDLE, WRITE} state_t;

  localparam logic [AW:0] MAX_CNT = MAX_WORDS[AW:0];

  state_t        state;
  logic          req;
  logic [AW-1:0] addr;
  logic [AW:0]   count;
  logic [31:0]   dout;
  logic          err;
  logic          full;
  logic          ready;
  logic          accept;
  logic          is_rtype;
  logic          imm_ok;
  logic [31:0]   word;

  assign full     = (count == MAX_CNT);
  assign ready    = RESET_N && (state == IDLE) && !full && !bus.LOAD_START;
  assign accept   = bus.IN_VALID && ready;
  assign is_rtype = (bus.OPCODE == 6'd0);
  // I-type immediates must survive truncation to a sign-extended 16-bit field
  assign imm_ok   = (&bus.IMM[31:15]) || !(|bus.IMM[31:15]);

  always_comb begin
    word = '0;
    if (is_rtype) word = {6'd0, bus.RS1, bus.RS2, bus.RD, 8'd0, bus.FUNC};
    else          word = {bus.OPCODE, bus.RS1, bus.RD, bus.IMM[15:0]};
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state <= IDLE;
      req   <= 1'b0;
      dout  <= '0;
      addr  <= BASE_ADDR;
      count <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.LOAD_START) begin
            addr  <= bus.START_ADDR;
            count <= '0;
            err   <= 1'b0;
          end else if (accept) begin
            if (!is_rtype && !imm_ok) begin
              err <= 1'b1;
            end else begin
              dout  <= word;
              req   <= 1'b1;
              state <= WRITE;
            end
          end
        end
        WRITE: begin
          // address and data stay frozen until the memory acknowledges
          if (bus.MEM_ACK) begin
            addr  <= addr + 1'b1;
            count <= count + 1'b1;
            req   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.IN_READY = ready;
  assign bus.MEM_REQ  = req;
  assign bus.MEM_WE   = req;
  assign bus.MEM_ADDR = addr;
  assign bus.MEM_DOUT = dout;
  assign bus.COUNT    = count;
  assign bus.FULL     = full;
  assign bus.ERR      = err;
endmodule
